// File: rtl/sha512_pkg.sv
//============================================================================
// Module      : sha512_pkg
// Description : Shared constants and state type for the SHA-512 message padder.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package sha512_pkg;

    localparam int CHUNK_BITS      = 1024;
    localparam int WORD_BITS       = 64;
    localparam int WORDS_PER_CHUNK = CHUNK_BITS / WORD_BITS;

    localparam logic [WORD_BITS-1:0] PAD_WORD_80 = 64'h8000_0000_0000_0000;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        PAD80 = 2'd1,
        LEN   = 2'd2,
        OUT   = 2'd3
    } pad_state_t;

endpackage

`default_nettype wire

// File: rtl/sha512_pad_word.sv
//============================================================================
// Module      : sha512_pad_word
// Description : Keeps the first nbytes bytes of a big-endian word, puts 0x80
//               in byte nbytes and zeroes the rest; nbytes >= 8 passes through.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module sha512_pad_word
    import sha512_pkg::*;
(
    input  logic [WORD_BITS-1:0] data,
    input  logic [3:0]           nbytes,
    output logic [WORD_BITS-1:0] word
);

    localparam int c_BYTES = WORD_BITS / 8;

    for (genvar b = 0; b < c_BYTES; b++) begin : g_byte
        assign word[WORD_BITS-1-8*b -: 8] =
            (4'(b) < nbytes)  ? data[WORD_BITS-1-8*b -: 8] :
            (4'(b) == nbytes) ? 8'h80 : 8'h00;
    end

endmodule

`default_nettype wire

// File: rtl/sha512_pad.sv
//============================================================================
// Module      : sha512_pad
// Description : FIPS 180-4 padder/chunker feeding the SHA-512 compressor.
//               Optional sticky error port enabled by SHA512_PAD_ERR_EN.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module sha512_pad
    import sha512_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_BITS-1:0]  in_data,
    input  logic                  in_last,
    input  logic [3:0]            in_bytes,
    output logic [CHUNK_BITS-1:0] chunk,
    output logic                  chunk_valid,
    input  logic                  chunk_ready,
    output logic                  chunk_first,
    output logic                  chunk_last
`ifdef SHA512_PAD_ERR_EN
    ,
    output logic                  err
`endif
);

    pad_state_t           r_state;
    pad_state_t           r_ret;
    pad_state_t           w_state_nxt;
    pad_state_t           w_ret_nxt;
    logic [4:0]           r_idx;
    logic [4:0]           w_idx_inc;
    logic [WORD_BITS-1:0] r_buf [WORDS_PER_CHUNK];
    logic [LEN_W-1:0]     r_byte_cnt;
    logic [LEN_W-1:0]     w_cnt_next;
    logic                 r_first;
    logic                 r_last;
    logic                 r_hold;
    logic [3:0]           w_nb;
    logic [3:0]           w_add;
    logic [WORD_BITS-1:0] w_word;
    logic [WORD_BITS-1:0] w_wr_data;
    logic                 w_wr_en;
    logic                 w_len_wr;
    logic                 w_handoff;
    logic                 w_accept;
    logic [127:0]         w_bitlen;

    assign w_nb      = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
    assign w_add     = in_last ? w_nb : 4'd8;
    assign w_accept  = in_valid && in_ready;
    assign w_idx_inc = r_idx + 5'd1;
    assign w_bitlen  = 128'({r_byte_cnt, 3'b000});

`ifdef SHA512_PAD_ERR_EN
    logic [LEN_W:0] w_cnt_sum;
    logic           r_err;

    assign w_cnt_sum  = {1'b0, r_byte_cnt} + (LEN_W+1)'(w_add);
    assign w_cnt_next = w_cnt_sum[LEN_W-1:0];
    assign err        = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_accept && ((in_last && (in_bytes > 4'd8)) || w_cnt_sum[LEN_W])) begin
            r_err <= 1'b1;
        end
    end
`else
    assign w_cnt_next = r_byte_cnt + LEN_W'(w_add);
`endif

    // Non-last words go through with nbytes=8, i.e. unmodified
    sha512_pad_word u_word (
        .data   (in_data),
        .nbytes (w_add),
        .word   (w_word)
    );

    assign in_ready    = (r_state == FILL) && !r_hold;
    assign chunk_valid = (r_state == OUT);
    assign chunk_first = r_first;
    assign chunk_last  = r_last;

    for (genvar i = 0; i < WORDS_PER_CHUNK; i++) begin : g_chunk
        assign chunk[CHUNK_BITS-1-WORD_BITS*i -: WORD_BITS] = r_buf[i];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ret_nxt   = r_ret;
        w_wr_en     = 1'b0;
        w_wr_data   = w_word;
        w_len_wr    = 1'b0;
        w_handoff   = 1'b0;
        unique case (r_state)
            FILL: begin
                if (w_accept) begin
                    w_wr_en = 1'b1;
                    if (!in_last) begin
                        if (w_idx_inc == 5'(WORDS_PER_CHUNK)) begin
                            w_state_nxt = OUT;
                            w_ret_nxt   = FILL;
                        end
                    end else if (w_nb != 4'd8) begin
                        // Length needs words 14 and 15 free
                        if (w_idx_inc <= 5'd14) begin
                            w_state_nxt = LEN;
                        end else begin
                            w_state_nxt = OUT;
                            w_ret_nxt   = LEN;
                        end
                    end else if (w_idx_inc == 5'(WORDS_PER_CHUNK)) begin
                        w_state_nxt = OUT;
                        w_ret_nxt   = PAD80;
                    end else begin
                        w_state_nxt = PAD80;
                    end
                end
            end
            PAD80: begin
                w_wr_en   = 1'b1;
                w_wr_data = PAD_WORD_80;
                if (w_idx_inc <= 5'd14) begin
                    w_state_nxt = LEN;
                end else begin
                    w_state_nxt = OUT;
                    w_ret_nxt   = LEN;
                end
            end
            LEN: begin
                w_len_wr    = 1'b1;
                w_state_nxt = OUT;
                w_ret_nxt   = FILL;
            end
            OUT: begin
                if (chunk_ready) begin
                    w_handoff   = 1'b1;
                    w_state_nxt = r_ret;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= FILL;
            r_ret      <= FILL;
            r_idx      <= '0;
            r_byte_cnt <= '0;
            r_first    <= 1'b1;
            r_last     <= 1'b0;
            r_hold     <= 1'b1;
            for (int i = 0; i < WORDS_PER_CHUNK; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_hold  <= 1'b0;
            r_state <= w_state_nxt;
            r_ret   <= w_ret_nxt;
            if (w_accept) begin
                r_byte_cnt <= w_cnt_next;
            end
            if (w_handoff) begin
                for (int i = 0; i < WORDS_PER_CHUNK; i++) begin
                    r_buf[i] <= '0;
                end
                r_idx   <= '0;
                r_first <= r_last;
                r_last  <= 1'b0;
                if (r_last) begin
                    r_byte_cnt <= '0;
                end
            end else begin
                if (w_wr_en) begin
                    r_buf[r_idx[3:0]] <= w_wr_data;
                    r_idx             <= w_idx_inc;
                end
                if (w_len_wr) begin
                    r_buf[14] <= w_bitlen[127:64];
                    r_buf[15] <= w_bitlen[63:0];
                    r_last    <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sha512_pad.sv
//============================================================================
// Module      : tb_sha512_pad
// Description : Randomized bench for sha512_pad against a byte-level padding model.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sha512_pad;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_data;
    logic          in_last;
    logic [3:0]    in_bytes;
    logic [1023:0] chunk;
    logic          chunk_valid;
    logic          chunk_ready;
    logic          chunk_first;
    logic          chunk_last;
`ifdef SHA512_PAD_ERR_EN
    logic          err;
`endif

    always #5 clk = ~clk;

    sha512_pad dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_bytes    (in_bytes),
        .chunk       (chunk),
        .chunk_valid (chunk_valid),
        .chunk_ready (chunk_ready),
        .chunk_first (chunk_first),
        .chunk_last  (chunk_last)
`ifdef SHA512_PAD_ERR_EN
        ,
        .err         (err)
`endif
    );

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic [3:0]  nb;
    } word_t;

    typedef struct {
        logic [1023:0] d;
        logic          f;
        logic          l;
    } chunk_t;

    word_t         wq[$];
    chunk_t        eq[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            n_acc = 0;
    int            stall_cnt = 0;
    bit            fire_in = 1'b0;
    bit            stall_mode = 1'b0;
    logic [1023:0] snap;
    logic          snap_f;
    logic          snap_l;
    logic [1023:0] got_chunk = '0;
    logic          got_first = 1'b0;
    logic          got_last = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Model: message bytes, 0x80, zeros to 112 mod 128, 128-bit big-endian bit length
    task automatic add_msg(input int len, input bit extra_zero, input bit abc);
        logic [7:0]   m[$];
        logic [7:0]   p[$];
        logic [127:0] bitlen;
        word_t        w;
        chunk_t       c;
        int           nw;
        int           nc;
        bit           extra;
        for (int i = 0; i < len; i++) m.push_back(abc ? 8'(8'h61 + i) : 8'($urandom));
        extra = (len == 0) || ((len % 8 == 0) && extra_zero);
        nw = (len + 7) / 8;
        for (int k = 0; k < nw; k++) begin
            w.data = {$urandom, $urandom};
            for (int j = 0; j < 8; j++)
                if (8*k + j < len) w.data[63-8*j -: 8] = m[8*k + j];
            w.last = !extra && (k == nw - 1);
            w.nb   = w.last ? 4'(len - 8*k) : 4'd8;
            wq.push_back(w);
        end
        if (extra) begin
            w.data = {$urandom, $urandom};
            w.last = 1'b1;
            w.nb   = 4'd0;
            wq.push_back(w);
        end
        p = m;
        p.push_back(8'h80);
        while (p.size() % 128 != 112) p.push_back(8'h00);
        bitlen = 128'(len) * 128'd8;
        for (int i = 15; i >= 0; i--) p.push_back(bitlen[8*i +: 8]);
        nc = p.size() / 128;
        for (int ci = 0; ci < nc; ci++) begin
            for (int j = 0; j < 128; j++) c.d[1023-8*j -: 8] = p[128*ci + j];
            c.f = (ci == 0);
            c.l = (ci == nc - 1);
            eq.push_back(c);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_bytes = '0; in_data = '0;
        chunk_ready = 1'b0; fire_in = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(chunk_valid), 64'd0);
        check("rst_chunk", 64'(|chunk), 64'd0);
        check("rst_first", 64'(chunk_first), 64'd1);
        check("rst_last",  64'(chunk_last),  64'd0);
        check("rst_ready", 64'(in_ready),    64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("ready_after_rst", 64'(in_ready), 64'd1);
        wq.delete(); eq.delete();
        n_acc = 0; stall_cnt = 0;
    endtask

    // stop_acc=0: drain all queued traffic; otherwise stop once stop_acc words accepted
    task automatic run(input int budget, input int stop_acc);
        int cyc = 0;
        while (((stop_acc == 0) ? (wq.size() != 0 || eq.size() != 0) : (n_acc < stop_acc))
               && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (fire_in) begin
                void'(wq.pop_front());
                n_acc++;
            end
            if (chunk_valid) begin
                if (stall_mode && stall_cnt < 5) begin
                    if (stall_cnt == 0) begin
                        snap = chunk; snap_f = chunk_first; snap_l = chunk_last;
                    end else begin
                        check("stall_chunk", 64'(chunk != snap), 64'd0);
                        check("stall_flags", 64'({chunk_first, chunk_last}), 64'({snap_f, snap_l}));
                    end
                    check("stall_in_ready", 64'(in_ready), 64'd0);
                    chunk_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    chunk_ready = ($urandom_range(0, 3) != 0);
                end
                if (chunk_ready) begin
                    if (eq.size() == 0) begin
                        check("extra_chunk", 64'(chunk_valid), 64'd0);
                    end else begin
                        for (int i = 0; i < 16; i++)
                            check($sformatf("chunk_w%0d", i), chunk[1023-64*i -: 64],
                                  eq[0].d[1023-64*i -: 64]);
                        check("chunk_first", 64'(chunk_first), 64'(eq[0].f));
                        check("chunk_last",  64'(chunk_last),  64'(eq[0].l));
                        void'(eq.pop_front());
                    end
                    got_chunk = chunk; got_first = chunk_first; got_last = chunk_last;
                    stall_cnt = 0;
                end
            end else begin
                chunk_ready = 1'($urandom_range(0, 1));
            end
            if (wq.size() != 0 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_data  = wq[0].data;
                in_last  = wq[0].last;
                in_bytes = wq[0].nb;
            end else begin
                in_valid = 1'b0;
                in_data  = {$urandom, $urandom};
                in_last  = 1'($urandom);
                in_bytes = 4'($urandom);
            end
            fire_in = in_valid && in_ready;
        end
        if (stop_acc == 0) begin
            check("drain", 64'(wq.size() + eq.size()), 64'd0);
            @(posedge clk);
            #1;
            chunk_ready = 1'b0;
            in_valid    = 1'b0;
            fire_in     = 1'b0;
            @(negedge clk);
            check("idle_after_drain", 64'(chunk_valid), 64'd0);
        end else begin
            check("words_accepted", 64'(n_acc >= stop_acc), 64'd1);
        end
    endtask

    initial begin
        int lens[17] = '{7, 8, 9, 111, 112, 113, 119, 120, 127, 128, 129, 239, 240, 247, 248, 255, 256};
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_bytes = '0;
        chunk_ready = 1'b0;
        do_reset();

        // abc, empty, 120 and 128 bytes back to back, each chunk held off 5 cycles
        stall_mode = 1'b1;
        add_msg(3, 1'b0, 1'b1);
        add_msg(0, 1'b0, 1'b0);
        add_msg(120, 1'b0, 1'b0);
        add_msg(128, 1'b0, 1'b0);
        run(4000, 0);
        stall_mode = 1'b0;

        foreach (lens[i]) add_msg(lens[i], 1'($urandom_range(0, 1)), 1'b0);
        repeat (20) add_msg(int'($urandom_range(0, 300)), 1'($urandom_range(0, 1)), 1'b0);
        run(20000, 0);

        // Reset mid-message, then abc must come out clean
        add_msg(200, 1'b0, 1'b0);
        run(2000, 7);
        do_reset();
        add_msg(3, 1'b0, 1'b1);
        run(500, 0);
        check("abc_w0",    got_chunk[1023:960], 64'h6162_6380_0000_0000);
        check("abc_w15",   got_chunk[63:0],     64'h0000_0000_0000_0018);
        check("abc_first", 64'(got_first), 64'd1);
        check("abc_last",  64'(got_last),  64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
